// File: rtl/hpdmc_wrseq.sv
// hpdmc_wrseq: write-burst output-enable sequencer for the DDR SDRAM DQ/DM/DQS pads.
// Walks WAIT -> PRE -> BURST -> POST -> TURN per write and chains back-to-back bursts.
module hpdmc_wrseq #(
    parameter int WLAT  = 1,
    parameter int BURST = 4,
    parameter int TURN  = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       write,
    output logic       write_ready,
    output logic       read_safe,
    output logic       write_done,
    output logic       overrun,
    output logic [1:0] dqs_t,
    output logic [1:0] dm_t,
    output logic       dq_t,
    output logic       dqs_toggle
);
    localparam int MAXC = (WLAT > TURN) ? WLAT : TURN;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(BURST);

    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
    localparam logic [BW-1:0] CHAIN_CNT  = BW'(BURST - 1 - WLAT);
    localparam logic [CW-1:0] WAIT_LAST  = CW'((WLAT >= 2) ? WLAT - 2 : 0);
    localparam logic [CW-1:0] TURN_LAST  = CW'(TURN - 1);

    // Pad control word layout: {dqs_t[1:0], dm_t[1:0], dq_t, dqs_toggle}
    localparam logic [5:0] PADS_HIZ    = 6'b11_11_1_0;
    localparam logic [5:0] PADS_STROBE = 6'b00_11_1_0;
    localparam logic [5:0] PADS_DATA   = 6'b00_00_0_1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRE,
        S_BURST,
        S_POST,
        S_TURN
    } state_e;

    localparam state_e START = (WLAT > 1) ? S_WAIT : S_PRE;

    state_e        state_q, state_d;
    logic [BW-1:0] burstCnt_q, burstCnt_d;
    logic [CW-1:0] seqCnt_q, seqCnt_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic [5:0]    pads_q, pads_d;
    logic          accept;

    // The chain window sits exactly BURST cycles after the write that opened this burst.
    assign write_ready = (state_q == S_IDLE) || (state_q == S_TURN) ||
                         ((state_q == S_BURST) && (burstCnt_q == CHAIN_CNT));
    assign accept      = write & write_ready;
    assign read_safe   = (state_q == S_IDLE);
    assign write_done  = (state_q == S_BURST) && (burstCnt_q == BURST_LAST);
    assign overrun     = overrun_q;
    assign {dqs_t, dm_t, dq_t, dqs_toggle} = pads_q;

    always_comb begin
        state_d    = state_q;
        burstCnt_d = burstCnt_q;
        seqCnt_d   = seqCnt_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q | (write & ~write_ready);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = START;
                    seqCnt_d = '0;
                end
            end
            S_WAIT: begin
                if (seqCnt_q == WAIT_LAST) begin
                    state_d = S_PRE;
                end else begin
                    seqCnt_d = seqCnt_q + CW'(1);
                end
            end
            S_PRE: begin
                state_d    = S_BURST;
                burstCnt_d = '0;
            end
            S_BURST: begin
                if (accept) begin
                    pending_d = 1'b1;
                end
                // A pending chained write restarts the counter so DQS never stops toggling.
                if (burstCnt_q == BURST_LAST) begin
                    burstCnt_d = '0;
                    if (pending_q) begin
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_POST;
                    end
                end else begin
                    burstCnt_d = burstCnt_q + BW'(1);
                end
            end
            S_POST: begin
                state_d  = S_TURN;
                seqCnt_d = '0;
            end
            S_TURN: begin
                if (accept) begin
                    state_d  = START;
                    seqCnt_d = '0;
                end else if (seqCnt_q == TURN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    seqCnt_d = seqCnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pads are decoded from the next state so they come straight out of flops.
    always_comb begin
        pads_d = PADS_HIZ;
        case (state_d)
            S_PRE, S_POST: pads_d = PADS_STROBE;
            S_BURST:       pads_d = PADS_DATA;
            default:       pads_d = PADS_HIZ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            burstCnt_q <= '0;
            seqCnt_q   <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            pads_q     <= PADS_HIZ;
        end else begin
            state_q    <= state_d;
            burstCnt_q <= burstCnt_d;
            seqCnt_q   <= seqCnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            pads_q     <= pads_d;
        end
    end

endmodule

// File: tb/tb_hpdmc_wrseq.sv
// tb_hpdmc_wrseq: directed vector table, hand-written corner cases and a randomized
// run against a timeline model of the write sequencer.
module tb_hpdmc_wrseq;
    localparam int WLAT  = 1;
    localparam int BURST = 4;
    localparam int TURN  = 2;

    typedef enum int {P_IDLE, P_WAIT, P_PRE, P_BURST, P_POST, P_TURN} phase_e;
    typedef enum logic [1:0] {PAD_Z, PAD_STROBE, PAD_DATA} pad_e;

    typedef struct {
        logic ready;
        logic safe;
        logic done;
        logic ovr;
        pad_e pads;
    } expect_t;

    typedef struct {
        logic    wr;
        expect_t exp;
    } vector_t;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       write     = 1'b0;
    logic       write_ready;
    logic       read_safe;
    logic       write_done;
    logic       overrun;
    logic [1:0] dqs_t;
    logic [1:0] dm_t;
    logic       dq_t;
    logic       dqs_toggle;

    int assertCount = 0;
    int failCount   = 0;

    vector_t tbl[$];

    // Timeline model: a sequence is an anchor write plus a number of chained bursts.
    bit mActive;
    bit mOverrun;
    int mAnchor;
    int mBursts;

    hpdmc_wrseq #(.WLAT(WLAT), .BURST(BURST), .TURN(TURN)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .write      (write),
        .write_ready(write_ready),
        .read_safe  (read_safe),
        .write_done (write_done),
        .overrun    (overrun),
        .dqs_t      (dqs_t),
        .dm_t       (dm_t),
        .dq_t       (dq_t),
        .dqs_toggle (dqs_toggle)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [5:0] padWord(input pad_e p);
        case (p)
            PAD_STROBE: return 6'b00_11_1_0;
            PAD_DATA:   return 6'b00_00_0_1;
            default:    return 6'b11_11_1_0;
        endcase
    endfunction

    task automatic compareAll(input string tag, input expect_t e);
        checkOutput({tag, " write_ready"}, 8'(write_ready), 8'(e.ready));
        checkOutput({tag, " read_safe"},   8'(read_safe),   8'(e.safe));
        checkOutput({tag, " write_done"},  8'(write_done),  8'(e.done));
        checkOutput({tag, " overrun"},     8'(overrun),     8'(e.ovr));
        checkOutput({tag, " pads{dqs,dm,dq,tog}"},
                    8'({dqs_t, dm_t, dq_t, dqs_toggle}), 8'(padWord(e.pads)));
    endtask

    // One clock cycle: drive just after the rising edge, leave sampling to the falling edge.
    task automatic applyStimulus(input logic w);
        @(posedge sys_clk);
        #1;
        write = w;
        @(negedge sys_clk);
    endtask

    task automatic resetDut();
        write     = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic addVec(input int n, input logic w, input logic r, input logic s,
                          input logic d, input logic o, input pad_e p);
        vector_t v;
        v.wr        = w;
        v.exp.ready = r;
        v.exp.safe  = s;
        v.exp.done  = d;
        v.exp.ovr   = o;
        v.exp.pads  = p;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    function automatic expect_t idleExpect(input logic ovr);
        expect_t e;
        e.ready = 1'b1;
        e.safe  = 1'b1;
        e.done  = 1'b0;
        e.ovr   = ovr;
        e.pads  = PAD_Z;
        return e;
    endfunction

    function automatic phase_e modelPhase(input int t);
        int d;
        int e;
        if (!mActive) return P_IDLE;
        d = t - mAnchor;
        e = WLAT + mBursts * BURST;
        if (d < WLAT)             return P_WAIT;
        if (d == WLAT)            return P_PRE;
        if (d <= e)               return P_BURST;
        if (d == e + 1)           return P_POST;
        if (d <= e + TURN + 1)    return P_TURN;
        return P_IDLE;
    endfunction

    function automatic expect_t modelExpect(input int t);
        expect_t e;
        phase_e  ph;
        int      d;
        ph = modelPhase(t);
        d  = t - mAnchor;
        e.ready = (ph == P_IDLE) || (ph == P_TURN) || ((ph == P_BURST) && (d == mBursts * BURST));
        e.safe  = (ph == P_IDLE);
        e.done  = (ph == P_BURST) && (((d - WLAT) % BURST) == 0);
        e.ovr   = mOverrun;
        case (ph)
            P_PRE, P_POST: e.pads = PAD_STROBE;
            P_BURST:       e.pads = PAD_DATA;
            default:       e.pads = PAD_Z;
        endcase
        return e;
    endfunction

    task automatic modelUpdate(input int t, input logic w, input expect_t e);
        if (w) begin
            if (e.ready) begin
                if (modelPhase(t) == P_BURST) begin
                    mBursts++;
                end else begin
                    mActive = 1'b1;
                    mAnchor = t;
                    mBursts = 1;
                end
            end else begin
                mOverrun = 1'b1;
            end
        end
    endtask

    initial begin
        logic    w;
        expect_t e;

        $display("[TB] start");
        resetDut();
        compareAll("reset state", idleExpect(1'b0));

        // single write, chained pair, illegal write, write during turnaround
        //     n  wr rdy safe done ovr pads
        addVec(1, 1, 1, 1, 0, 0, PAD_Z);
        addVec(1, 0, 0, 0, 0, 0, PAD_STROBE);
        addVec(2, 0, 0, 0, 0, 0, PAD_DATA);
        addVec(1, 0, 1, 0, 0, 0, PAD_DATA);
        addVec(1, 0, 0, 0, 1, 0, PAD_DATA);
        addVec(1, 0, 0, 0, 0, 0, PAD_STROBE);
        addVec(2, 0, 1, 0, 0, 0, PAD_Z);
        addVec(1, 0, 1, 1, 0, 0, PAD_Z);
        addVec(1, 1, 1, 1, 0, 0, PAD_Z);
        addVec(1, 0, 0, 0, 0, 0, PAD_STROBE);
        addVec(2, 0, 0, 0, 0, 0, PAD_DATA);
        addVec(1, 1, 1, 0, 0, 0, PAD_DATA);
        addVec(1, 0, 0, 0, 1, 0, PAD_DATA);
        addVec(2, 0, 0, 0, 0, 0, PAD_DATA);
        addVec(1, 0, 1, 0, 0, 0, PAD_DATA);
        addVec(1, 0, 0, 0, 1, 0, PAD_DATA);
        addVec(1, 0, 0, 0, 0, 0, PAD_STROBE);
        addVec(2, 0, 1, 0, 0, 0, PAD_Z);
        addVec(1, 0, 1, 1, 0, 0, PAD_Z);
        addVec(1, 1, 1, 1, 0, 0, PAD_Z);
        addVec(1, 0, 0, 0, 0, 0, PAD_STROBE);
        addVec(1, 0, 0, 0, 0, 0, PAD_DATA);
        addVec(1, 1, 0, 0, 0, 0, PAD_DATA);
        addVec(1, 0, 1, 0, 0, 1, PAD_DATA);
        addVec(1, 0, 0, 0, 1, 1, PAD_DATA);
        addVec(1, 0, 0, 0, 0, 1, PAD_STROBE);
        addVec(2, 0, 1, 0, 0, 1, PAD_Z);
        addVec(1, 0, 1, 1, 0, 1, PAD_Z);
        addVec(1, 1, 1, 1, 0, 1, PAD_Z);
        addVec(1, 0, 0, 0, 0, 1, PAD_STROBE);
        addVec(2, 0, 0, 0, 0, 1, PAD_DATA);
        addVec(1, 0, 1, 0, 0, 1, PAD_DATA);
        addVec(1, 0, 0, 0, 1, 1, PAD_DATA);
        addVec(1, 0, 0, 0, 0, 1, PAD_STROBE);
        addVec(1, 1, 1, 0, 0, 1, PAD_Z);
        addVec(1, 0, 0, 0, 0, 1, PAD_STROBE);
        addVec(2, 0, 0, 0, 0, 1, PAD_DATA);
        addVec(1, 0, 1, 0, 0, 1, PAD_DATA);
        addVec(1, 0, 0, 0, 1, 1, PAD_DATA);
        addVec(1, 0, 0, 0, 0, 1, PAD_STROBE);
        addVec(2, 0, 1, 0, 0, 1, PAD_Z);
        addVec(1, 0, 1, 1, 0, 1, PAD_Z);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].wr);
            compareAll($sformatf("table c%0d", i), tbl[i].exp);
        end

        // idle stability for 100 cycles after reset
        resetDut();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0);
            compareAll($sformatf("idle c%0d", i), idleExpect(1'b0));
        end

        // reset mid-burst must release the pads before any clock edge
        resetDut();
        applyStimulus(1'b1);
        repeat (3) applyStimulus(1'b0);
        checkOutput("midburst dq_t", 8'(dq_t), 8'h00);
        checkOutput("midburst dqs_toggle", 8'(dqs_toggle), 8'h01);
        #1;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async reset pads{dqs,dm,dq,tog}",
                    8'({dqs_t, dm_t, dq_t, dqs_toggle}), 8'(padWord(PAD_Z)));
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        compareAll("after async reset", idleExpect(1'b0));
        applyStimulus(1'b0);
        compareAll("after async reset +1", idleExpect(1'b0));

        // randomized segments with different write densities
        for (int seg = 0; seg < 4; seg++) begin
            resetDut();
            mActive  = 1'b0;
            mOverrun = 1'b0;
            mAnchor  = 0;
            mBursts  = 0;
            for (int t = 0; t < 400; t++) begin
                e = modelExpect(t);
                case (seg)
                    0:       w = ($urandom_range(0, 2) == 0);
                    1:       w = e.ready && ($urandom_range(0, 1) == 1);
                    2:       w = ($urandom_range(0, 7) == 0);
                    default: w = e.ready;
                endcase
                applyStimulus(w);
                compareAll($sformatf("rand s%0d c%0d", seg, t), e);
                modelUpdate(t, w, e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hpdmc_wrseq.md
# hpdmc_wrseq

Write-burst output-enable sequencer for the 16-bit DDR SDRAM controller. It takes the write-command strobe from the command scheduler and drives the tristate controls of the DQ, DM and DQS pad buffers, plus the DQS toggle enable, through the sequence wait → preamble → burst → postamble → bus turnaround. It also tells the scheduler when another write may be issued, including seamless back-to-back chaining. It tells the scheduler when the bus is released for reads.

## Interface
Parameters:
- WLAT, 1: cycles from write command to DQS preamble; legal range 1 ≤ WLAT ≤ BURST-1.
- BURST, 4: sys_clk cycles of data per write burst; ≥ 2.
- TURN, 2: idle cycles after postamble before reads are permitted; ≥ 1.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- write  in  1  write command issued to SDRAM this cycle; meaningful only when write_ready=1.
- write_ready  out  1  a write asserted this cycle is accepted.
- read_safe  out  1  data bus released and turnaround done; scheduler issues reads only when 1.
- write_done  out  1  one-cycle pulse on the last data cycle of each burst.
- overrun  out  1  sticky; set when write=1 while write_ready=0; cleared only by reset.
- dqs_t  out  2  DQS pad tristate per byte lane; 1 = high-Z.
- dm_t  out  2  DM pad tristate per byte lane; 1 = high-Z.
- dq_t  out  1  DQ[15:0] pad tristate; 1 = high-Z.
- dqs_toggle  out  1  DQS toggle enable to the DDR output registers; 0 = DQS held low.

## Operation
- States: IDLE, WAIT, PRE, BURST, POST, TURN. Burst counter 0..BURST-1. WAIT/TURN counter sized for max(WLAT, TURN).
- Output decode per state:
  - IDLE, WAIT, TURN: dqs_t=11, dm_t=11, dq_t=1, dqs_toggle=0.
  - PRE and POST: dqs_t=00, dm_t=11, dq_t=1, dqs_toggle=0.
  - BURST: dqs_t=00, dm_t=00, dq_t=0, dqs_toggle=1.
- All pad controls are registered; no combinational path from write to the pads.
- Transitions:
  - IDLE or TURN + accepted write: go to WAIT if WLAT>1, else PRE.
  - WAIT lasts WLAT-1 cycles, then PRE.
  - PRE lasts 1 cycle, then BURST.
  - BURST lasts BURST cycles, then POST, unless a chained write is pending, in which case the counter restarts and BURST continues.
  - POST lasts 1 cycle, then TURN.
  - TURN lasts TURN cycles, then IDLE.
- write_ready:
  - 1 in IDLE and TURN.
  - 1 in the chain window: the cycle exactly BURST cycles after the previously accepted write (BURST state, counter = BURST-1-WLAT).
  - 0 in every other cycle.
- A chained write sets a pending flag. At the end of the current burst there is no POST and no PRE; DQS keeps toggling.
- A write while write_ready=0 is ignored: no state change, and overrun is set.
- read_safe=1 only in IDLE.
- write_done=1 in every cycle where state=BURST and counter=BURST-1.
- Reset values: state IDLE, write_ready=1, read_safe=1, write_done=0, overrun=0, dqs_t=11, dm_t=11, dq_t=1, dqs_toggle=0, pending=0.
- Reset assertion mid-burst releases all pads to high-Z asynchronously, without waiting for a clock edge.

## Timing
Write accepted in cycle 0:
- WAIT: cycles 1..WLAT-1.
- PRE: cycle WLAT.
- BURST: cycles WLAT+1..WLAT+BURST.
- POST: cycle WLAT+BURST+1.
- TURN: cycles WLAT+BURST+2..WLAT+BURST+TURN+1.
- read_safe first returns to 1 in cycle WLAT+BURST+TURN+2.

Other timing rules:
- Chained write in cycle BURST: its data occupies cycles WLAT+BURST+1..WLAT+2·BURST, contiguous with the previous burst.
- A write accepted during TURN restarts the sequence with the same latency as from IDLE. read_safe stays 0.
- Latency from write to first pad enable (PRE) is WLAT cycles. Write acceptance is single-cycle; there is no stall.

## Test plan
All scenarios use WLAT=1, BURST=4, TURN=2.
- **Single write.** write at cycle 0 → PRE at cycle 1 (dqs_t=00, dq_t=1); BURST cycles 2–5 (dq_t=0, dm_t=00, dqs_toggle=1); write_done at cycle 5; POST at cycle 6; TURN at cycles 7–8; read_safe=1 from cycle 9.
- **Chained writes.** writes at cycles 0 and 4 → continuous BURST cycles 2–9; no PRE/POST between bursts; write_done at cycles 5 and 9; POST at cycle 10; read_safe=1 from cycle 13.
- **Illegal write.** write at cycle 0, then write at cycle 3 → second write ignored, overrun=1 from cycle 4 onward, POST at cycle 6 as in the single-write case.
- **Write during turnaround.** write at cycle 0, then write at cycle 7 → PRE at cycle 8, BURST cycles 9–12; read_safe stays 0 until cycle 16.
- **Reset mid-burst.** sys_rst_n low at cycle 3 (mid-cycle) → dqs_t=11, dm_t=11, dq_t=1, dqs_toggle=0 immediately, before the next edge; after release, state is IDLE with write_ready=1 and read_safe=1.
- **Idle stability.** no writes for 100 cycles after reset → all pads high-Z, write_done never pulses, overrun=0.
